// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode field values, the canonical NOP,
// the default address width and the fetch FSM state encoding.
package riscv_pkg;

  localparam int ADDR_W = 32;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] SAVE   = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] JTYPE  = 7'b1101111;
  localparam logic [6:0] JRTYPE = 7'b1100111;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_REQ     = 2'b01,
    S_DISCARD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {instruction, pc} pairs.
// Storage is registered; the head entry is read straight from the storage
// registers. Flush empties the FIFO and overrides a same-cycle push or pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !flush && !empty;
  assign do_push_s = push && !flush && (!full || do_pop_s);

  // Pointer and occupancy update; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until first push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential I-cache reads with a held-request
// handshake, buffers returned words in fetch_fifo and presents them to ID.
// A redirect flushes the buffer and restarts fetch; a request already on the
// bus is never withdrawn, its returning word is simply dropped.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              icache_read,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic [31:0]       icache_rdata,
  input  logic              icache_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  import riscv_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e             state_r;
  logic [ADDR_W-1:0]        pc_r;
  logic [ADDR_W-1:0]        pc_next_s;
  logic [ADDR_W-1:0]        target_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [CW-1:0]            fifo_count_s;
  logic [CW-1:0]            post_count_s;
  logic [32+ADDR_W-1:0]     fifo_head_s;

  assign pc_next_s = pc_r + ADDR_W'(4);
  assign target_s  = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign push_s    = (state_r == S_REQ) && !icache_stall && !redirect_valid;
  assign pop_s     = if_valid && !id_stall;

  // Occupancy after this cycle's accepted word, counting a same-cycle pop
  always_comb begin
    post_count_s = fifo_count_s + CW'(1);
    if (pop_s) begin
      post_count_s = fifo_count_s;
    end else begin
      post_count_s = fifo_count_s + CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (32 + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   ({icache_rdata, icache_addr}),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .head  (fifo_head_s)
  );

  assign if_valid = !fifo_empty_s;
  assign if_instr = fifo_head_s[32+ADDR_W-1:ADDR_W];
  assign if_pc    = fifo_head_s[ADDR_W-1:0];

  // Fetch FSM with registered request outputs; a live request keeps read/addr
  // frozen until the cache accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      icache_read <= 1'b0;
      icache_addr <= RESET_PC;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (redirect_valid) begin
            pc_r        <= target_s;
            icache_addr <= target_s;
            icache_read <= 1'b1;
            state_r     <= S_REQ;
          end else if (!fifo_full_s) begin
            icache_addr <= pc_r;
            icache_read <= 1'b1;
            state_r     <= S_REQ;
          end else begin
            icache_read <= 1'b0;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc_r <= target_s;
            if (icache_stall) begin
              state_r <= S_DISCARD;
            end else begin
              icache_addr <= target_s;
            end
          end else if (!icache_stall) begin
            pc_r        <= pc_next_s;
            icache_addr <= pc_next_s;
            if (post_count_s < DEPTH_C) begin
              icache_read <= 1'b1;
            end else begin
              icache_read <= 1'b0;
              state_r     <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          // A redirect arriving as the abandoned word returns goes straight
          // to the new target instead of re-reading the dead address
          if (redirect_valid) begin
            pc_r <= target_s;
            if (!icache_stall) begin
              icache_addr <= target_s;
              state_r     <= S_REQ;
            end
          end else if (!icache_stall) begin
            icache_addr <= pc_r;
            state_r     <= S_REQ;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          icache_read <= 1'b0;
          icache_addr <= pc_r;
        end
      endcase
    end
  end

endmodule
